// File: rtl/traceback_stream_engine.sv
// Traceback engine: walks a direction matrix from (len_a,len_b) back to (0,0)
// and streams aligned symbol pairs with a running signed alignment score.
module traceback_stream_engine #(
  parameter int N        = 128,
  parameter int BitAddr  = $clog2(N+1),
  parameter int SCORE_W  = $clog2(N+1)+3,
  parameter int MATCH    = 1,
  parameter int MISMATCH = -1,
  parameter int GAP      = -2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [BitAddr-1:0]        len_a,
  input  logic [BitAddr-1:0]        len_b,
  output logic [BitAddr-1:0]        dir_i,
  output logic [BitAddr-1:0]        dir_j,
  input  logic [2:0]                symbol,
  output logic [BitAddr-1:0]        seq_a_addr,
  output logic [BitAddr-1:0]        seq_b_addr,
  input  logic [2:0]                seq_a_dat,
  input  logic [2:0]                seq_b_dat,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2:0]                out_a,
  output logic [2:0]                out_b,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic signed [SCORE_W-1:0] final_score,
  output logic [BitAddr:0]          step_count
);

  localparam logic [2:0] SYM_DIAG = 3'b001;
  localparam logic [2:0] SYM_UP   = 3'b010;
  localparam logic [2:0] SYM_LEFT = 3'b100;
  localparam logic [2:0] GAP_CODE = 3'b111;

  localparam logic [BitAddr-1:0]        ADDR_ONE   = BitAddr'(1);
  localparam logic [BitAddr-1:0]        N_SAT      = BitAddr'(N);
  localparam logic [BitAddr:0]          STEP_ONE   = (BitAddr+1)'(1);
  localparam logic signed [SCORE_W-1:0] D_MATCH    = SCORE_W'(MATCH);
  localparam logic signed [SCORE_W-1:0] D_MISMATCH = SCORE_W'(MISMATCH);
  localparam logic signed [SCORE_W-1:0] D_GAP      = SCORE_W'(GAP);

  typedef enum logic [2:0] {IDLE, ADDR, READ, EMIT, FINISH} state_t;

  state_t state, state_nxt;

  logic [BitAddr-1:0]        i, j;
  logic [BitAddr-1:0]        la_sat, lb_sat;
  logic [BitAddr-1:0]        i_nxt, j_nxt;
  logic signed [SCORE_W-1:0] score, delta, score_nxt;
  logic                      mv_i, mv_j;

  logic                      mv_i_c, mv_j_c, bad_c, last_c;
  logic [2:0]                pa_c, pb_c;
  logic signed [SCORE_W-1:0] delta_c;

  assign la_sat    = (len_a > N_SAT) ? N_SAT : len_a;
  assign lb_sat    = (len_b > N_SAT) ? N_SAT : len_b;
  assign i_nxt     = i - BitAddr'(mv_i);
  assign j_nxt     = j - BitAddr'(mv_j);
  assign score_nxt = score + delta;

  // Move decode for READ; an exhausted axis forces the other direction.
  always_comb begin
    mv_i_c = 1'b0;
    mv_j_c = 1'b0;
    bad_c  = 1'b0;
    if (i == '0) begin
      mv_j_c = 1'b1;
    end else if (j == '0) begin
      mv_i_c = 1'b1;
    end else begin
      case (symbol)
        SYM_DIAG: begin
          mv_i_c = 1'b1;
          mv_j_c = 1'b1;
        end
        SYM_UP:   mv_i_c = 1'b1;
        SYM_LEFT: mv_j_c = 1'b1;
        default:  bad_c  = 1'b1;
      endcase
    end
  end

  always_comb begin
    pa_c    = mv_i_c ? seq_a_dat : GAP_CODE;
    pb_c    = mv_j_c ? seq_b_dat : GAP_CODE;
    delta_c = D_GAP;
    if (mv_i_c && mv_j_c) begin
      delta_c = (seq_a_dat == seq_b_dat) ? D_MATCH : D_MISMATCH;
    end
    last_c  = ((i - BitAddr'(mv_i_c)) == '0) && ((j - BitAddr'(mv_j_c)) == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (len_a == '0 && len_b == '0) ? FINISH : ADDR;
        end
      end
      ADDR:   state_nxt = READ;
      READ:   state_nxt = bad_c ? FINISH : EMIT;
      EMIT: begin
        if (out_ready) begin
          state_nxt = out_last ? FINISH : ADDR;
        end
      end
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign out_valid = (state == EMIT);
  assign busy      = (state == ADDR) || (state == READ) || (state == EMIT);
  assign done      = (state == FINISH);

  // final_score is written on the transition into FINISH so it is already
  // valid while done is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i           <= '0;
      j           <= '0;
      dir_i       <= '0;
      dir_j       <= '0;
      seq_a_addr  <= '0;
      seq_b_addr  <= '0;
      out_a       <= '0;
      out_b       <= '0;
      out_last    <= 1'b0;
      err         <= 1'b0;
      score       <= '0;
      delta       <= '0;
      final_score <= '0;
      step_count  <= '0;
      mv_i        <= 1'b0;
      mv_j        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            i           <= la_sat;
            j           <= lb_sat;
            dir_i       <= la_sat;
            dir_j       <= lb_sat;
            seq_a_addr  <= la_sat - ADDR_ONE;
            seq_b_addr  <= lb_sat - ADDR_ONE;
            score       <= '0;
            final_score <= '0;
            step_count  <= '0;
            err         <= 1'b0;
            out_last    <= 1'b0;
          end
        end
        READ: begin
          if (bad_c) begin
            err         <= 1'b1;
            final_score <= score;
          end else begin
            out_a    <= pa_c;
            out_b    <= pb_c;
            delta    <= delta_c;
            mv_i     <= mv_i_c;
            mv_j     <= mv_j_c;
            out_last <= last_c;
          end
        end
        EMIT: begin
          if (out_ready) begin
            score      <= score_nxt;
            step_count <= step_count + STEP_ONE;
            i          <= i_nxt;
            j          <= j_nxt;
            dir_i      <= i_nxt;
            dir_j      <= j_nxt;
            seq_a_addr <= i_nxt - ADDR_ONE;
            seq_b_addr <= j_nxt - ADDR_ONE;
            out_last   <= 1'b0;
            if (out_last) begin
              final_score <= score_nxt;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_traceback_stream_engine.sv
// Scoreboard bench for traceback_stream_engine (N=8) with synchronous RAM models.
module tb_traceback_stream_engine;

  localparam int N  = 8;
  localparam int BA = $clog2(N+1);
  localparam int SW = $clog2(N+1)+3;

  logic                 clk = 1'b0;
  logic                 rst, start, out_ready;
  logic [BA-1:0]        len_a, len_b;
  logic [BA-1:0]        dir_i, dir_j, seq_a_addr, seq_b_addr;
  logic [2:0]           symbol, seq_a_dat, seq_b_dat;
  logic                 out_valid, out_last, busy, done, err;
  logic [2:0]           out_a, out_b;
  logic signed [SW-1:0] final_score;
  logic [BA:0]          step_count;

  traceback_stream_engine #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .len_a(len_a), .len_b(len_b),
    .dir_i(dir_i), .dir_j(dir_j), .symbol(symbol),
    .seq_a_addr(seq_a_addr), .seq_b_addr(seq_b_addr),
    .seq_a_dat(seq_a_dat), .seq_b_dat(seq_b_dat),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_last(out_last), .busy(busy), .done(done), .err(err),
    .final_score(final_score), .step_count(step_count)
  );

  always #5 clk = ~clk;

  logic [2:0] a_mem [16];
  logic [2:0] b_mem [16];
  logic [2:0] dir_mem [16][16];

  always @(posedge clk) begin
    symbol    <= dir_mem[dir_i][dir_j];
    seq_a_dat <= a_mem[seq_a_addr];
    seq_b_dat <= b_mem[seq_b_addr];
  end

  typedef struct {int score; int steps; int err;} done_t;
  logic [6:0] pair_q [$];
  done_t      done_q [$];

  int n_checks = 0;
  int n_fail   = 0;
  int lat;
  int cyc;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expire(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired, got no event expected one", name);
  endtask

  task automatic exp_pair(input int a, input int b, input bit last);
    pair_q.push_back({3'(a), 3'(b), last});
  endtask

  task automatic exp_done(input int score, input int steps, input int e);
    done_t d;
    d.score = score; d.steps = steps; d.err = e;
    done_q.push_back(d);
  endtask

  // Monitor: pops expectations whenever the DUT presents a transfer or done.
  always @(negedge clk) begin
    logic [6:0] p;
    done_t d;
    if (rst) begin
      if (out_valid && out_ready) begin
        if (pair_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pair: out_a=%0d out_b=%0d expected none", out_a, out_b);
        end else begin
          p = pair_q.pop_front();
          chk("pair_a", int'(out_a), int'(p[6:4]));
          chk("pair_b", int'(out_b), int'(p[3:1]));
          chk("pair_last", int'(out_last), int'(p[0]));
        end
      end
      if (done) begin
        if (prev_done) chk("done_width", int'(done), 0);
        else if (done_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: done=1 expected 0");
        end else begin
          d = done_q.pop_front();
          chk("final_score", int'(final_score), d.score);
          chk("step_count", int'(step_count), d.steps);
          chk("err", int'(err), d.err);
          chk("busy_at_done", int'(busy), 0);
        end
      end
      prev_done <= done;
    end else begin
      prev_done <= 1'b0;
    end
  end

  task automatic clear_mem();
    for (int unsigned x = 0; x < 16; x++) begin
      a_mem[x] = '0;
      b_mem[x] = '0;
      for (int unsigned y = 0; y < 16; y++) dir_mem[x][y] = '0;
    end
  endtask

  task automatic start_run(input int la, input int lb);
    len_a = BA'(la);
    len_b = BA'(lb);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    cyc = 0;
    while (!done && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) expire(name);
    lat = cyc;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; out_ready = 1'b1; len_a = '0; len_b = '0;
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_score", int'(final_score), 0);
    chk("rst_steps", int'(step_count), 0);
    chk("rst_dir_i", int'(dir_i), 0);
    chk("rst_addr_a", int'(seq_a_addr), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // All-diag identical sequences, latency check.
    clear_mem();
    a_mem[0] = 1; a_mem[1] = 2; a_mem[2] = 3;
    b_mem[0] = 1; b_mem[1] = 2; b_mem[2] = 3;
    dir_mem[3][3] = 3'b001; dir_mem[2][2] = 3'b001; dir_mem[1][1] = 3'b001;
    exp_pair(3, 3, 0); exp_pair(2, 2, 0); exp_pair(1, 1, 1);
    exp_done(3, 3, 0);
    start_run(3, 3);
    wait_done("t1_done");
    chk("t1_latency", lat, 9);
    repeat (2) @(posedge clk);
    #1;
    chk("t1_hold_score", int'(final_score), 3);
    chk("t1_hold_steps", int'(step_count), 3);

    // j=0 forces up moves regardless of symbol.
    clear_mem();
    a_mem[0] = 4; a_mem[1] = 5;
    for (int unsigned x = 0; x < 16; x++)
      for (int unsigned y = 0; y < 16; y++) dir_mem[x][y] = 3'b001;
    exp_pair(5, 7, 0); exp_pair(4, 7, 1);
    exp_done(-4, 2, 0);
    start_run(2, 0);
    wait_done("t2_done");

    // Stall on the first EMIT; up, then mismatch diag, then match diag.
    clear_mem();
    a_mem[0] = 1; a_mem[1] = 2; a_mem[2] = 6;
    b_mem[0] = 1; b_mem[1] = 3;
    dir_mem[3][2] = 3'b010; dir_mem[2][2] = 3'b001; dir_mem[1][1] = 3'b001;
    exp_pair(6, 7, 0); exp_pair(2, 3, 0); exp_pair(1, 1, 1);
    exp_done(-2, 3, 0);
    out_ready = 1'b0;
    start_run(3, 2);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!out_valid) expire("t3_valid");
    for (int k = 0; k < 5; k++) begin
      chk("t3_stall_valid", int'(out_valid), 1);
      chk("t3_stall_a", int'(out_a), 6);
      chk("t3_stall_b", int'(out_b), 7);
      chk("t3_stall_steps", int'(step_count), 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_done("t3_done");

    // Up, left, then illegal symbol at (2,2).
    clear_mem();
    a_mem[0] = 1; a_mem[1] = 2; a_mem[2] = 3;
    b_mem[0] = 4; b_mem[1] = 5; b_mem[2] = 6;
    dir_mem[3][3] = 3'b010; dir_mem[2][3] = 3'b100; dir_mem[2][2] = 3'b000;
    exp_pair(3, 7, 0); exp_pair(7, 6, 0);
    exp_done(-4, 2, 1);
    start_run(3, 3);
    wait_done("t4_done");

    // Reset during the third EMIT of a 5-step run.
    clear_mem();
    for (int unsigned x = 0; x < 5; x++) begin
      a_mem[x] = 3'(x + 1);
      b_mem[x] = 3'(x + 1);
      dir_mem[x+1][x+1] = 3'b001;
    end
    exp_pair(5, 5, 0); exp_pair(4, 4, 0);
    start_run(5, 5);
    cyc = 0;
    while (!(out_valid && step_count == 2) && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!(out_valid && step_count == 2)) expire("t5_third_emit");
    #2 rst = 1'b0;
    #1;
    chk("t5_rst_valid", int'(out_valid), 0);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_steps", int'(step_count), 0);
    chk("t5_rst_addr_b", int'(seq_b_addr), 0);
    chk("t5_rst_out_a", int'(out_a), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_idle_busy", int'(busy), 0);
    clear_mem();
    a_mem[0] = 1; a_mem[1] = 2; b_mem[0] = 1;
    dir_mem[2][1] = 3'b010; dir_mem[1][1] = 3'b001;
    exp_pair(2, 7, 0); exp_pair(1, 1, 1);
    exp_done(-1, 2, 0);
    start_run(2, 1);
    wait_done("t5_done");

    // Start while busy is ignored.
    clear_mem();
    a_mem[0] = 1; a_mem[1] = 2; b_mem[0] = 1; b_mem[1] = 2;
    dir_mem[2][2] = 3'b001; dir_mem[1][1] = 3'b001;
    exp_pair(2, 2, 0); exp_pair(1, 1, 1);
    exp_done(2, 2, 0);
    start_run(2, 2);
    @(posedge clk); #1;
    start_run(0, 0);
    wait_done("t6_done");

    // Empty alignment.
    exp_done(0, 0, 0);
    start_run(0, 0);
    wait_done("t7_done");
    chk("t7_latency", lat, 0);

    // Length saturation to N.
    clear_mem();
    a_mem[0] = 1; a_mem[1] = 2; a_mem[2] = 3; a_mem[3] = 4;
    a_mem[4] = 5; a_mem[5] = 6; a_mem[6] = 1; a_mem[7] = 2;
    for (int k = 7; k >= 0; k--) exp_pair(int'(a_mem[k]), 7, k == 0);
    exp_done(-16, 8, 0);
    start_run(12, 0);
    wait_done("t8_done");

    repeat (3) @(posedge clk);
    #1;
    chk("pairs_left", pair_q.size(), 0);
    chk("dones_left", done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/traceback_stream_engine.md
TRACEBACK_STREAM_ENGINE -- requirements
Module: traceback_stream_engine

Interface
REQ-001 Parameter N, default 128, maximum sequence length per operand.
REQ-002 Parameter BitAddr, default $clog2(N+1), matrix coordinate width.
REQ-003 Parameter SCORE_W, default $clog2(N+1)+3, signed score width.
REQ-004 Parameters MATCH, MISMATCH, GAP, defaults +1, -1, -2, signed per-step scores.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle pulse; begins traceback; ignored unless idle.
REQ-008 len_a, len_b  in  BitAddr  lengths of SeqA and SeqB, sampled on accepted start.
REQ-009 dir_i, dir_j  out  BitAddr  direction-RAM read coordinates.
REQ-010 symbol  in  3  direction-RAM data; 3'b001 diag, 3'b010 up (i-1), 3'b100 left (j-1); other codes illegal.
REQ-011 seq_a_addr, seq_b_addr  out  BitAddr  sequence-RAM read addresses, equal to i-1 and j-1.
REQ-012 seq_a_dat, seq_b_dat  in  3  nucleotide codes; 3'b111 reserved as gap.
REQ-013 out_valid  out  1 / out_ready  in  1  aligned-pair stream handshake.
REQ-014 out_a, out_b  out  3  aligned pair; 3'b111 marks a gap.
REQ-015 out_last  out  1  high with the final pair of the alignment.
REQ-016 busy, done, err  out  1  engine active / one-cycle completion pulse / illegal-symbol flag.
REQ-017 final_score  out  SCORE_W signed  accumulated alignment score.
REQ-018 step_count  out  BitAddr+1  pairs emitted in the current or last run.

Function
REQ-019 FSM states IDLE, ADDR, READ, EMIT, FINISH; exactly one active.
REQ-020 IDLE + start: load i=len_a, j=len_b, clear score and step_count, assert busy, go ADDR; if len_a=len_b=0, go FINISH with no pairs.
REQ-021 ADDR: drive dir_i=i, dir_j=j, seq_a_addr=i-1, seq_b_addr=j-1 (addresses held stable through READ and EMIT); go READ.
REQ-022 READ: RAMs are synchronous, one-cycle latency; sample symbol, seq_a_dat, seq_b_dat; form pair and score delta; go EMIT.
REQ-023 Boundary override in READ: i=0 forces left, j=0 forces up, regardless of symbol.
REQ-024 Diag: out_a=seq_a_dat, out_b=seq_b_dat, delta MATCH if equal else MISMATCH; up: out_a=seq_a_dat, out_b=3'b111, delta GAP; left: out_a=3'b111, out_b=seq_b_dat, delta GAP.
REQ-025 Illegal symbol with i>0 and j>0: set err, emit no pair, go FINISH.
REQ-026 EMIT: out_valid high; out_a, out_b, out_last stable while out_valid=1 and out_ready=0.
REQ-027 Transfer on out_valid & out_ready: add delta to score, increment step_count, decrement i and/or j per direction; next coordinate (0,0) goes FINISH, else ADDR.
REQ-028 out_last=1 exactly when the pending move reaches (0,0).
REQ-029 Throughput: 3 cycles per pair with out_ready held high; each stall cycle adds one.
REQ-030 FINISH: register final_score, pulse done one cycle, deassert busy, go IDLE; final_score, step_count, err hold until next accepted start.
REQ-031 start while busy is ignored; no queueing.
REQ-032 Score arithmetic signed two's complement at SCORE_W; no saturation (default width covers 2N steps at |delta|<=2).
REQ-033 len_a or len_b > N: saturate the value to N on load.

Reset
REQ-034 rst=0 asynchronously forces IDLE, i=j=0, all address outputs 0, out_valid=0, out_a=out_b=0, out_last=0, busy=0, done=0, err=0, final_score=0, step_count=0.
REQ-035 Reset mid-operation abandons the run with no done pulse; first cycle after release is IDLE.

Verification
REQ-036 len_a=len_b=3, all symbols diag, A=B, out_ready=1 -> 3 pairs, out_last on 3rd, final_score=+3, done 9-10 cycles after start.
REQ-037 len_a=2, len_b=0 -> two up pairs (A,gap), final_score=-4, step_count=2, symbol ignored.
REQ-038 out_ready low 5 cycles during EMIT -> out_a/out_b/out_valid stable, score and step_count unchanged until transfer.
REQ-039 symbol=3'b000 at (2,2) -> err=1, done pulse, no out_valid, final_score=sum of prior deltas.
REQ-040 rst low during third EMIT of a 5-step run -> all outputs at reset values immediately, no done, new start runs cleanly.
REQ-041 start pulsed while busy -> ignored, run completes unchanged; len_a=len_b=0 -> done with step_count=0, final_score=0, out_valid never high.
